serializer_10b: RTL
===================

Name: serializer_10b

Overview:
- Transmit-side stage directly downstream of the 8b/10b encoder.
- Accepts 10-bit code groups through a valid/ready handshake and shifts them out one bit per enabled clock, bit 9 first. The encoder's out_10b[9] is line bit "a", so bit "a" goes out first.
- Holds one symbol in a single-entry buffer. When no data is pending at a symbol boundary, it inserts a programmable idle/comma symbol so the line never starves.

Parameters:
- SYM_W, 10, code-group width. Only 10 is supported.
- IDLE_SYM, 10'b0011111010, filler symbol (K28.5, RD-, bit order abcdei fghj).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  bit-rate enable; all shifting, counting and loading happen only on cycles with en=1.
- data_in  in  10  encoded symbol; [9]=a … [0]=j.
- valid_in  in  1  data_in is valid.
- ready_out  out  1  block can accept data_in this cycle (combinational).
- serial_out  out  1  registered serial line bit.
- sym_start  out  1  registered; high while serial_out carries bit "a" of a symbol.
- idle_out  out  1  registered; high for all 10 bit-times of an inserted IDLE_SYM.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - serial_out=0, sym_start=0, idle_out=0.
  - bit counter cnt=0, hold_valid=0, hold register=0, shift register=IDLE_SYM.
- Reset has priority over everything. Asserting it mid-symbol aborts that symbol and discards buffered data. The first en cycle after reset is a symbol boundary.
- Counter: cnt is 4 bits and counts 0..9, advancing only when en=1. It wraps 9→0. A cycle with en=1 and cnt==0 is a "boundary".
- At a boundary:
  - If hold_valid=1, load the hold register as the next symbol and set idle_out<=0.
  - Otherwise load IDLE_SYM and set idle_out<=1.
  - In both cases: shift register <= loaded symbol, serial_out <= loaded[9], sym_start <= 1, cnt <= 1.
- On en cycles with cnt=k (1..9): serial_out <= shift register bit [9-k], sym_start <= 0, cnt <= k+1 (or 0 when k=9). idle_out holds its value.
- On en=0 cycles, all registers hold, including serial_out and sym_start. Nothing is accepted unless hold is empty.
- Handshake:
  - ready_out = ~hold_valid | (en & cnt==0).
  - accept = valid_in & ready_out.
  - On accept: hold register <= data_in, hold_valid <= 1.
- Simultaneous events at a boundary:
  - hold_valid=1 with accept: the old hold content is loaded into the shift register, new data_in goes into hold, and hold_valid stays 1.
  - hold_valid=1 without accept: hold_valid <= 0.
  - hold_valid=0 with accept: IDLE_SYM is loaded and data_in is captured into hold. There is no same-cycle bypass.
- Latency: a symbol accepted when hold is empty and cnt≠0 starts at the next boundary, giving sym_start 1 enabled cycle after that boundary. valid_in with ready_out=0 is ignored (the sender must hold it). Data is never dropped or duplicated.
- Throughput: with en=1 continuously and valid_in always high, there is one symbol per 10 clocks and no idle insertion after the first.
- No running-disparity tracking is done here. Symbols are transmitted exactly as supplied.

Test Plan:
- Reset, then en=1 and valid_in=0 for 30 cycles → three consecutive IDLE_SYM symbols, serial sequence 0,0,1,1,1,1,1,0,1,0 repeated. sym_start pulses every 10 cycles, idle_out=1 throughout.
- Single push of 10'b1010101010 while hold is empty mid-symbol → ready_out=1, accepted. At the next boundary the output is 1,0,1,0,1,0,1,0,1,0 with idle_out=0, then IDLE_SYM resumes.
- Back-to-back stream 10'h3FF, 10'h000, 10'h2AA with valid_in held high → ready_out low while hold is full and high on boundary cycles. Output is 10 ones, 10 zeros, then 1010101010 with no idle between them.
- en asserted 1 cycle in 4 → each bit lasts 4 clocks, serial_out stable between enables, symbol content and order unchanged.
- reset pulsed when cnt=5 with hold full → all outputs return to reset values, the held symbol is discarded, and the first post-reset symbol is IDLE_SYM.
- valid_in exactly on a boundary cycle with hold_valid=1 → old hold symbol is transmitted, new symbol follows next boundary, and no loss is reported by the scoreboard.

Source files
------------

// File: rtl/serializer_10b.sv
// ---------------------------------------------------------------------------
// serializer_10b
//
// Transmit-side serializer placed directly after the 8b/10b encoder. It takes
// 10-bit code groups over a valid/ready handshake and sends them out one bit
// per enabled clock, bit 9 ("a") first. One symbol can wait in a single-entry
// hold buffer. If nothing is waiting when a symbol boundary arrives, the
// IDLE_SYM filler goes out instead, so the line never starves.
//
// Ports:
//   clk         single clock
//   reset       synchronous, active-high reset; overrides everything else
//   en          bit-rate enable; state changes only on cycles with en=1
//   data_in     encoded symbol, [9]=a ... [0]=j
//   valid_in    data_in is valid
//   ready_out   block can accept data_in this cycle (combinational)
//   serial_out  registered serial line bit
//   sym_start   registered; high while serial_out carries bit "a"
//   idle_out    registered; high for all bit-times of an inserted IDLE_SYM
// ---------------------------------------------------------------------------
module serializer_10b #(
    parameter int               SYM_W    = 10,
    parameter logic [SYM_W-1:0] IDLE_SYM = 10'b0011111010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [SYM_W-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             serial_out,
    output logic             sym_start,
    output logic             idle_out
);

    localparam logic [3:0] LAST_BIT = 4'(SYM_W - 1);

    logic [3:0]       cnt_q, cnt_d;
    logic             hold_valid_q, hold_valid_d;
    logic [SYM_W-1:0] hold_q, hold_d;
    logic [SYM_W-1:0] shift_q, shift_d;
    logic             serial_q, serial_d;
    logic             sym_start_q, sym_start_d;
    logic             idle_q, idle_d;

    logic             boundary;
    logic             accept;
    logic [SYM_W-1:0] next_sym;
    logic [3:0]       bit_idx;

    // An enabled cycle with cnt==0 starts a new symbol. The hold entry drains
    // on that same cycle, so it can be refilled then even if it is full.
    assign boundary  = en && (cnt_q == 4'd0);
    assign ready_out = !hold_valid_q || boundary;
    assign accept    = valid_in && ready_out;

    // Symbol to launch at a boundary. The launch takes the buffered entry
    // only. A word accepted on the same cycle does not bypass into the
    // shifter.
    assign next_sym = hold_valid_q ? hold_q : IDLE_SYM;
    // Bit "a" is index 9, so bit-time k carries shift register bit [9-k].
    assign bit_idx  = LAST_BIT - cnt_q;

    always_comb begin
        // NOTE: every signal gets a default here so the block can never infer a latch.
        cnt_d        = cnt_q;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        shift_d      = shift_q;
        serial_d     = serial_q;
        sym_start_d  = sym_start_q;
        idle_d       = idle_q;

        if (boundary) begin
            shift_d      = next_sym;
            serial_d     = next_sym[SYM_W-1];
            sym_start_d  = 1'b1;
            idle_d       = !hold_valid_q;
            cnt_d        = 4'd1;
            hold_valid_d = 1'b0;        // an accept below on this cycle refills it
        end else if (en) begin
            serial_d    = shift_q[bit_idx];
            sym_start_d = 1'b0;
            cnt_d       = (cnt_q == LAST_BIT) ? 4'd0 : cnt_q + 4'd1;
        end

        if (accept) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the hold register has no memory array behind it. It is one register and gets a defined reset value like the rest.
            cnt_q        <= 4'd0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            shift_q      <= IDLE_SYM;
            serial_q     <= 1'b0;
            sym_start_q  <= 1'b0;
            idle_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            shift_q      <= shift_d;
            serial_q     <= serial_d;
            sym_start_q  <= sym_start_d;
            idle_q       <= idle_d;
        end
    end

    assign serial_out = serial_q;
    assign sym_start  = sym_start_q;
    assign idle_out   = idle_q;

endmodule
